// File: rtl/fb_rxstatem_if.sv
// PHY-nibble / Rx-status bundle for the FREEDM bus receive state machine.
// The PHY side is the master; the state machine is the slave.
interface fb_rxstatem_if;
  logic        MRxDV;
  logic [3:0]  MRxD;
  logic        StateIdle;
  logic        StatePreamble;
  logic [1:0]  StateSoC;
  logic [1:0]  StatePayload;
  logic        StateDrop;
  logic [2:0]  RxFrmType;
  logic [7:0]  RxByte;
  logic        RxByteValid;
  logic [15:0] RxByteCnt;
  logic        RxEndFrm;
  logic        RxAbort;

  modport master (
    output MRxDV, MRxD,
    input  StateIdle, StatePreamble, StateSoC, StatePayload, StateDrop,
    input  RxFrmType, RxByte, RxByteValid, RxByteCnt, RxEndFrm, RxAbort
  );

  modport slave (
    input  MRxDV, MRxD,
    output StateIdle, StatePreamble, StateSoC, StatePayload, StateDrop,
    output RxFrmType, RxByte, RxByteValid, RxByteCnt, RxEndFrm, RxAbort
  );
endinterface

// File: rtl/fb_rxstatem.sv
// FREEDM bus MAC receive state machine: preamble/SFD/SoC tracking, nibble-to-byte
// assembly, byte counting and end-of-frame / abort signalling.
module fb_rxstatem #(
  parameter logic [3:0]  MIN_PRE      = 4'd7,
  parameter logic [7:0]  SOC_NUMB     = 8'h01,
  parameter logic [7:0]  SOC_DIST     = 8'h02,
  parameter logic [7:0]  SOC_DELAY    = 8'h03,
  parameter logic [7:0]  SOC_DLYDIST  = 8'h04,
  parameter logic [7:0]  SOC_DATA     = 8'h05,
  parameter logic [15:0] NUMB_BYTES   = 16'd6,
  parameter logic [15:0] DIST_BYTES   = 16'd6,
  parameter logic [15:0] DELAY_BYTES  = 16'd6,
  parameter logic [15:0] DLYDIST_BYTES = 16'd6,
  parameter logic [15:0] MAX_BYTES    = 16'd1518
) (
  input logic           MRxClk,
  input logic           Reset,
  fb_rxstatem_if.slave  rx
);

  localparam logic [3:0] NibPre = 4'h5;
  localparam logic [3:0] NibSfd = 4'hD;
  localparam logic [2:0] TypeData = 3'd5;

  // One-hot encoding so each state output is a plain register bit.
  typedef enum logic [6:0] {
    StIdle = 7'b000_0001,
    StPre  = 7'b000_0010,
    StSoc0 = 7'b000_0100,
    StSoc1 = 7'b000_1000,
    StPay0 = 7'b001_0000,
    StPay1 = 7'b010_0000,
    StDrop = 7'b100_0000
  } state_e;

  state_e      state_q;
  logic [3:0]  pre_cnt_q;
  logic [3:0]  low_q;
  logic [2:0]  frm_type_q;
  logic [7:0]  byte_q;
  logic        byte_valid_q;
  logic [15:0] byte_cnt_q;
  logic        end_q;
  logic        abort_q;

  logic [7:0]  soc_byte;
  logic [2:0]  soc_type;
  logic [15:0] byte_limit;
  logic        frame_ok;

  assign soc_byte = {rx.MRxD, low_q};

  always_comb begin
    soc_type = 3'd0;
    if      (soc_byte == SOC_NUMB)    soc_type = 3'd1;
    else if (soc_byte == SOC_DIST)    soc_type = 3'd2;
    else if (soc_byte == SOC_DELAY)   soc_type = 3'd3;
    else if (soc_byte == SOC_DLYDIST) soc_type = 3'd4;
    else if (soc_byte == SOC_DATA)    soc_type = 3'd5;
  end

  always_comb begin
    byte_limit = 16'd0;
    unique case (frm_type_q)
      3'd1:    byte_limit = NUMB_BYTES;
      3'd2:    byte_limit = DIST_BYTES;
      3'd3:    byte_limit = DELAY_BYTES;
      3'd4:    byte_limit = DLYDIST_BYTES;
      3'd5:    byte_limit = MAX_BYTES;
      default: byte_limit = 16'd0;
    endcase
  end

  // Data frames accept a length range; fixed types must hit their length exactly.
  always_comb begin
    frame_ok = 1'b0;
    if (frm_type_q == TypeData) begin
      frame_ok = (byte_cnt_q >= 16'd4) && (byte_cnt_q <= MAX_BYTES);
    end else begin
      frame_ok = (byte_cnt_q == byte_limit);
    end
  end

  always_ff @(posedge MRxClk or posedge Reset) begin
    if (Reset) begin
      state_q      <= StIdle;
      pre_cnt_q    <= 4'd0;
      low_q        <= 4'd0;
      frm_type_q   <= 3'd0;
      byte_q       <= 8'd0;
      byte_valid_q <= 1'b0;
      byte_cnt_q   <= 16'd0;
      end_q        <= 1'b0;
      abort_q      <= 1'b0;
    end else begin
      byte_valid_q <= 1'b0;
      end_q        <= 1'b0;
      abort_q      <= 1'b0;
      unique case (state_q)
        StIdle: begin
          if (rx.MRxDV) begin
            if (rx.MRxD == NibPre) begin
              state_q   <= StPre;
              pre_cnt_q <= 4'd1;
            end else begin
              state_q <= StDrop;
              abort_q <= 1'b1;
            end
          end
        end
        StPre: begin
          if (!rx.MRxDV) begin
            state_q <= StIdle;
          end else if (rx.MRxD == NibPre) begin
            if (pre_cnt_q != 4'hF) pre_cnt_q <= pre_cnt_q + 4'd1;
          end else if (rx.MRxD == NibSfd && pre_cnt_q >= MIN_PRE) begin
            state_q <= StSoc0;
          end else begin
            state_q <= StDrop;
            abort_q <= 1'b1;
          end
        end
        StSoc0: begin
          if (!rx.MRxDV) begin
            state_q <= StIdle;
            abort_q <= 1'b1;
          end else begin
            low_q   <= rx.MRxD;
            state_q <= StSoc1;
          end
        end
        StSoc1: begin
          if (!rx.MRxDV) begin
            state_q <= StIdle;
            abort_q <= 1'b1;
          end else if (soc_type != 3'd0) begin
            frm_type_q <= soc_type;
            byte_cnt_q <= 16'd0;
            state_q    <= StPay0;
          end else begin
            state_q <= StDrop;
            abort_q <= 1'b1;
          end
        end
        StPay0: begin
          if (!rx.MRxDV) begin
            state_q <= StIdle;
            if (frame_ok) end_q   <= 1'b1;
            else          abort_q <= 1'b1;
          end else begin
            low_q   <= rx.MRxD;
            state_q <= StPay1;
          end
        end
        StPay1: begin
          if (!rx.MRxDV) begin
            state_q <= StIdle;
            abort_q <= 1'b1;
          end else if (byte_cnt_q >= byte_limit) begin
            // Over-length byte is discarded and the count frozen.
            state_q <= StDrop;
            abort_q <= 1'b1;
          end else begin
            byte_q       <= {rx.MRxD, low_q};
            byte_valid_q <= 1'b1;
            byte_cnt_q   <= byte_cnt_q + 16'd1;
            state_q      <= StPay0;
          end
        end
        StDrop: begin
          if (!rx.MRxDV) state_q <= StIdle;
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  assign rx.StateIdle     = state_q[0];
  assign rx.StatePreamble = state_q[1];
  assign rx.StateSoC      = state_q[3:2];
  assign rx.StatePayload  = state_q[5:4];
  assign rx.StateDrop     = state_q[6];
  assign rx.RxFrmType     = frm_type_q;
  assign rx.RxByte        = byte_q;
  assign rx.RxByteValid   = byte_valid_q;
  assign rx.RxByteCnt     = byte_cnt_q;
  assign rx.RxEndFrm      = end_q;
  assign rx.RxAbort       = abort_q;

endmodule
